// File: rtl/graph_poly_seq.sv
// Sequential Horner polynomial evaluator with snapshot coefficient bank and draw-flag compare.
// Optional: define GRAPH_POLY_SAT_EN to saturate out_p to CORDW instead of wrapping.
module graph_poly_seq #(
   parameter int CORDW = 12,
   parameter int DEG   = 3,
   parameter int ACCW  = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             coef_we,
   input  logic [2:0]       coef_addr,
   input  logic [CORDW-1:0] coef_data,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [CORDW-1:0] req_x,
   input  logic [CORDW-1:0] req_y,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [CORDW-1:0] out_p,
   output logic             out_r
);

   typedef enum logic [1:0] {IDLE, LOAD, MAC, DONE} state_t;

   localparam logic [3:0] DEG_W  = 4'(DEG);
   localparam logic [2:0] DEG_I  = 3'(DEG);
   localparam logic [2:0] DEG_M1 = 3'(DEG - 1);

   state_t            state, state_nxt;
   logic [CORDW-1:0]  coef   [0:7];
   logic [CORDW-1:0]  snap_c [0:7];
   logic [CORDW-1:0]  snap_x, snap_y;
   logic [ACCW-1:0]   acc;
   logic [2:0]        cnt;
   logic              accept, coef_ok;
   logic [CORDW-1:0]  coef_sel;
   logic [ACCW-1:0]   coef_ext, x_ext, acc_mac;
   logic [CORDW-1:0]  p_red;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      req_ready = 1'b0;
      out_valid = 1'b0;
      case (state)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) state_nxt = LOAD;
         end
         LOAD: state_nxt = MAC;
         MAC:  if (cnt == '0) state_nxt = DONE;
         DONE: begin
            out_valid = 1'b1;
            req_ready = out_ready;
            if (out_ready) state_nxt = req_valid ? LOAD : IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign accept  = req_valid && req_ready;
   assign coef_ok = ({1'b0, coef_addr} <= DEG_W);

   // LOAD seeds with c_DEG; each MAC step folds in c_cnt
   assign coef_sel = (state == LOAD) ? snap_c[DEG_I] : snap_c[cnt];
   assign coef_ext = {{(ACCW-CORDW){coef_sel[CORDW-1]}}, coef_sel};
   assign x_ext    = {{(ACCW-CORDW){snap_x[CORDW-1]}}, snap_x};
   assign acc_mac  = acc * x_ext + coef_ext;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc    <= '0;
         cnt    <= '0;
         snap_x <= '0;
         snap_y <= '0;
         for (int unsigned i = 0; i < 8; i++) begin
            coef[i]   <= '0;
            snap_c[i] <= '0;
         end
      end else begin
         if (coef_we && coef_ok) coef[coef_addr] <= coef_data;
         if (accept) begin
            snap_x <= req_x;
            snap_y <= req_y;
            for (int unsigned i = 0; i < 8; i++) snap_c[i] <= coef[i];
         end
         case (state)
            LOAD: begin
               acc <= coef_ext;
               cnt <= DEG_M1;
            end
            MAC: begin
               acc <= acc_mac;
               if (cnt != '0) cnt <= cnt - 3'd1;
            end
            default: ;
         endcase
      end
   end

`ifdef GRAPH_POLY_SAT_EN
   logic [ACCW-CORDW:0] acc_hi;
   assign acc_hi = acc[ACCW-1:CORDW-1];
   always_comb begin
      if ((&acc_hi) || ~(|acc_hi)) p_red = acc[CORDW-1:0];
      else if (acc[ACCW-1])        p_red = {1'b1, {(CORDW-1){1'b0}}};
      else                         p_red = {1'b0, {(CORDW-1){1'b1}}};
   end
`else
   assign p_red = acc[CORDW-1:0];
`endif

   assign out_p = p_red;
   assign out_r = (state == DONE) && (p_red == snap_y);

endmodule

// File: tb/tb_graph_poly_seq.sv
// Scoreboard bench for graph_poly_seq: direct power-sum reference model, randomized requests.
module tb_graph_poly_seq;

   localparam int CORDW = 12;
   localparam int DEG   = 3;
   localparam int ACCW  = 32;
   localparam int PMAX  = 2**(CORDW-1) - 1;
   localparam int PMIN  = -(2**(CORDW-1));

   logic             clk = 1'b0;
   logic             rst;
   logic             coef_we;
   logic [2:0]       coef_addr;
   logic [CORDW-1:0] coef_data;
   logic             req_valid, req_ready;
   logic [CORDW-1:0] req_x, req_y;
   logic             out_valid, out_ready;
   logic [CORDW-1:0] out_p;
   logic             out_r;

   graph_poly_seq #(.CORDW(CORDW), .DEG(DEG), .ACCW(ACCW)) dut (
      .clk(clk), .rst(rst), .coef_we(coef_we), .coef_addr(coef_addr),
      .coef_data(coef_data), .req_valid(req_valid), .req_ready(req_ready),
      .req_x(req_x), .req_y(req_y), .out_valid(out_valid), .out_ready(out_ready),
      .out_p(out_p), .out_r(out_r)
   );

   always #5 clk = ~clk;

   typedef struct {
      int     p;
      bit     r;
      longint acc_cyc;
   } exp_t;

   exp_t   q[$];
   int     mc[0:DEG];
   int     errors = 0;
   int     checks = 0;
   longint cyc = 0;
   bit     seen = 1'b0;
   int     last_p = 0;
   int     ready_mode = 0;

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic fail_timeout(input string name);
      checks++;
      errors++;
      $display("FAIL %s: got timeout expected event (t=%0t)", name, $time);
   endtask

   function automatic int reduce(input longint s);
      logic [63:0]      u;
      int               a;
      logic [CORDW-1:0] w;
      u = s;
      a = u[ACCW-1:0];
`ifdef GRAPH_POLY_SAT_EN
      if (a > PMAX) return PMAX;
      if (a < PMIN) return PMIN;
      return a;
`else
      w = a[CORDW-1:0];
      return $signed(w);
`endif
   endfunction

   // p(x) as a plain sum of c_k * x^k; low ACCW bits are exact under 64-bit wrap
   function automatic int p_model(input int x);
      longint s  = 0;
      longint pw = 1;
      for (int k = 0; k <= DEG; k++) begin
         s  += longint'(mc[k]) * pw;
         pw *= x;
      end
      return reduce(s);
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      #2;
      case (ready_mode)
         0:       out_ready = 1'b1;
         1:       out_ready = 1'($urandom_range(0, 1));
         default: out_ready = 1'b0;
      endcase
   end

   // monitor first (sees state before this cycle's acceptance), then request tracker
   always @(negedge clk) begin : sb
      exp_t e;
      int   exp_rdy;
      if (rst) begin
         q.delete();
         seen = 1'b0;
         for (int k = 0; k <= DEG; k++) mc[k] = 0;
         chk("rst_out_valid", out_valid, 0);
         chk("rst_out_r", out_r, 0);
         chk("rst_out_p", $signed(out_p), 0);
      end else begin
         exp_rdy = (q.size() == 0) ? 1 : (out_valid ? int'(out_ready) : 0);
         chk("req_ready", req_ready, exp_rdy);
         if (out_valid) begin
            if (q.size() == 0) chk("spurious_out_valid", out_valid, 0);
            else begin
               if (!seen) begin
                  chk("latency", cyc - q[0].acc_cyc, DEG + 1);
                  seen = 1'b1;
               end
               chk("out_p", $signed(out_p), q[0].p);
               chk("out_r", out_r, q[0].r);
               if (out_ready) begin
                  last_p = $signed(out_p);
                  void'(q.pop_front());
                  seen = 1'b0;
               end
            end
         end else begin
            chk("out_r_idle", out_r, 0);
         end
         if (req_valid && req_ready) begin
            e.p       = p_model($signed(req_x));
            e.r       = (e.p == $signed(req_y));
            e.acc_cyc = cyc + 1;
            q.push_back(e);
         end
         if (coef_we && (coef_addr <= DEG)) mc[coef_addr] = $signed(coef_data);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input int k, input int v);
      coef_we   = 1'b1;
      coef_addr = k[2:0];
      coef_data = v[CORDW-1:0];
      tick();
      coef_we   = 1'b0;
   endtask

   task automatic send(input int x, input int y);
      bit ok = 1'b0;
      req_x     = x[CORDW-1:0];
      req_y     = y[CORDW-1:0];
      req_valid = 1'b1;
      for (int i = 0; i < 200 && !ok; i++) begin
         @(negedge clk);
         if (req_ready) ok = 1'b1;
         tick();
      end
      req_valid = 1'b0;
      if (!ok) fail_timeout("accept");
   endtask

   task automatic drain();
      bit ok = 1'b0;
      for (int i = 0; i < 400 && !ok; i++) begin
         @(negedge clk);
         #1;
         if (q.size() == 0) ok = 1'b1;
      end
      if (!ok) fail_timeout("drain");
      tick();
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1);
   end

   initial begin
      int x, y;
      bit ok;
      rst = 1'b1; coef_we = 1'b0; coef_addr = '0; coef_data = '0;
      req_valid = 1'b0; req_x = '0; req_y = '0; out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("reset_req_ready", req_ready, 1);
      chk("reset_out_p", $signed(out_p), 0);
      tick();

      // x^2 at x=5 with matching y
      wr(2, 1);
      send(5, 25); drain();
      chk("sq5_p", last_p, 25);

      // x^3 - 2x + 3 at x=-3
      wr(3, 1); wr(2, 0); wr(1, -2); wr(0, 3);
      send(-3, 0); drain();
      chk("cubic_p", last_p, -18);

      // x^2 at x=100 overflows CORDW
      wr(3, 0); wr(1, 0); wr(0, 0); wr(2, 1);
      send(100, 0); drain();
`ifdef GRAPH_POLY_SAT_EN
      chk("ovf_p", last_p, 2047);
`else
      chk("ovf_p", last_p, 1808);
`endif

      // consumer stall then back-to-back acceptance
      ready_mode = 2;
      send(7, 49);
      ok = 1'b0;
      for (int i = 0; i < 50 && !ok; i++) begin
         @(negedge clk);
         if (out_valid) ok = 1'b1;
      end
      if (!ok) fail_timeout("stall_valid");
      repeat (10) begin
         @(negedge clk);
         #1;
         chk("hold_p", $signed(out_p), 49);
         chk("hold_req_ready", req_ready, 0);
      end
      @(posedge clk);
      #1;
      ready_mode = 0;
      req_x = 12'd3; req_y = 12'd9; req_valid = 1'b1;
      @(negedge clk);
      chk("b2b_req_ready", req_ready, 1);
      tick();
      req_valid = 1'b0;
      drain();
      chk("b2b_p", last_p, 9);

      // coefficient write while evaluating uses the snapshot
      send(2, 0);
      tick();
      wr(0, 7);
      drain();
      chk("midwrite_p", last_p, 4);
      send(2, 11); drain();
      chk("after_write_p", last_p, 11);

      // write and acceptance on the same edge: snapshot holds pre-write c0
      coef_we = 1'b1; coef_addr = 3'd0; coef_data = 12'hFFB;
      req_x = 12'd1; req_y = 12'd8; req_valid = 1'b1;
      tick();
      coef_we = 1'b0; req_valid = 1'b0;
      drain();
      chk("same_edge_p", last_p, 8);

      // address above DEG is ignored
      wr(5, 100);
      send(1, 0); drain();
      chk("ignored_addr_p", last_p, -4);

      // randomized traffic
      ready_mode = 1;
      for (int n = 0; n < 60; n++) begin
         for (int w = 0; w < int'($urandom_range(0, 2)); w++)
            wr(int'($urandom_range(0, 7)), int'($urandom_range(0, 4095)) - 2048);
         if ($urandom_range(0, 1) != 0) x = int'($urandom_range(0, 40)) - 20;
         else                           x = int'($urandom_range(0, 4095)) - 2048;
         if ($urandom_range(0, 1) != 0) y = p_model(x);
         else                           y = int'($urandom_range(0, 4095)) - 2048;
         send(x, y);
         if ($urandom_range(0, 3) == 0) drain();
      end
      drain();

      // reset during MAC discards the request and clears the bank
      ready_mode = 0;
      wr(1, 1); wr(3, 2);
      send(9, 0);
      tick();
      rst = 1'b1;
      tick(); tick();
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_req_ready", req_ready, 1);
      repeat (10) begin
         @(negedge clk);
         #1;
         chk("post_rst_no_valid", out_valid, 0);
      end
      tick();
      send(9, 0); drain();
      chk("zero_bank_p9", last_p, 0);
      send(-1234, 0); drain();
      chk("zero_bank_pneg", last_p, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/graph_poly_seq.md
GRAPH_POLY_SEQ -- requirements
Module: graph_poly_seq

Interface
REQ-001 Parameter CORDW, default 12: signed width of x, y and result.
REQ-002 Parameter DEG, default 3: polynomial degree; legal range 1..7.
REQ-003 Parameter ACCW, default 32: signed accumulator width; ACCW >= 2*CORDW.
REQ-004 clk  in  1  clock; all state changes on rising edge.
REQ-005 rst  in  1  reset; asynchronous, active-high.
REQ-006 coef_we  in  1  coefficient write strobe.
REQ-007 coef_addr  in  3  coefficient index k (c_k multiplies x^k).
REQ-008 coef_data  in  CORDW  signed coefficient value.
REQ-009 req_valid  in  1  evaluation request present.
REQ-010 req_ready  out  1  block accepts request this cycle.
REQ-011 req_x  in  CORDW  signed function input x.
REQ-012 req_y  in  CORDW  signed screen y for comparison.
REQ-013 out_valid  out  1  result present.
REQ-014 out_ready  in  1  consumer accepts result.
REQ-015 out_p  out  CORDW  signed p(x).
REQ-016 out_r  out  1  draw flag: out_p == captured req_y.

Function
REQ-017 Block SHALL evaluate p(x) = sum c_k*x^k, k=0..DEG, by Horner's method on one shared multiply-add, one step per cycle.
REQ-018 FSM states SHALL be IDLE, LOAD, MAC, DONE.
REQ-019 Request SHALL be accepted when req_valid && req_ready; req_x, req_y and the whole coefficient bank SHALL be captured into a snapshot at acceptance.
REQ-020 req_ready SHALL be 1 in IDLE, and in DONE only when out_ready is 1; 0 in LOAD and MAC.
REQ-021 IDLE -> LOAD on acceptance; LOAD sets acc = sign-extended c_DEG, step counter = DEG-1.
REQ-022 LOAD -> MAC; each MAC cycle SHALL set acc = (acc*x)[ACCW-1:0] + c_k, k = counter, counter decrements; MAC -> DONE after the c_0 step (DEG MAC cycles).
REQ-023 Latency: out_valid SHALL rise exactly DEG+1 cycles after the acceptance edge.
REQ-024 In DONE out_valid=1; out_p, out_r SHALL hold stable until out_ready=1.
REQ-025 DONE with out_ready=1: -> LOAD if req_valid (back-to-back accept), else -> IDLE.
REQ-026 Accumulator arithmetic SHALL wrap modulo 2^ACCW; no overflow flag.
REQ-027 out_p SHALL be acc reduced to CORDW per REQ-040/041; out_r = (out_p == snapshot y).
REQ-028 coef_we SHALL update c_[coef_addr] on the edge in any state; in-flight evaluation SHALL use the snapshot, new value applies from next acceptance.
REQ-029 coef_we with coef_addr > DEG SHALL be ignored.
REQ-030 coef_we and acceptance in same cycle: snapshot SHALL take the pre-write value.
REQ-031 out_valid, out_r SHALL be 0 outside DONE.

Reset
REQ-032 rst SHALL force state IDLE immediately, regardless of clock.
REQ-033 Reset values: req_ready=1 after rst deasserts, out_valid=0, out_p=0, out_r=0, acc=0, counter=0.
REQ-034 Coefficients SHALL reset to 0 (p(x)=0 for all x).
REQ-035 rst mid-evaluation SHALL discard the request; no out_valid emitted for it.

Configuration
REQ-040 With GRAPH_POLY_SAT_EN defined: out_p SHALL saturate acc to [-2^(CORDW-1), 2^(CORDW-1)-1].
REQ-041 Without GRAPH_POLY_SAT_EN: out_p SHALL be acc[CORDW-1:0] (two's-complement wrap).
REQ-042 Macro SHALL not change latency, handshake or intermediate ACCW wrap.

Verification (CORDW=12, DEG=3, ACCW=32)
REQ-050 c2=1, others 0; req x=5,y=25 -> out_valid 4 cycles after accept, out_p=25, out_r=1.
REQ-051 c3=1,c1=-2,c0=3; x=-3,y=0 -> out_p=-18, out_r=0.
REQ-052 c2=1; x=100 -> out_p=2047 with GRAPH_POLY_SAT_EN, 1808 without.
REQ-053 out_ready=0 for 10 cycles in DONE -> out_p stable, req_ready=0; then out_ready=1 with req_valid=1 -> accepted same cycle, next out_valid 4 cycles later.
REQ-054 Write c0=7 during MAC of x=2 (c2=1) -> out_p=4; next request x=2 -> out_p=11.
REQ-055 Assert rst in MAC -> out_valid never rises for that request, req_ready=1 after release, c_k all read 0.
